// File: rtl/score_counter.sv
// score_counter: game score keeper for the runner game.
//   Counts score points at a fixed clk2 rate while a game is running,
//   derives a 0..7 speed level (one step per 100 points), and tracks
//   the best score since reset.
// Ports:
//   clk2      in   sole clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse, begins a new game from IDLE/OVER
//   collide   in   level, ends the running game
//   score     out  [SCORELEN] current score, saturates at SCORE_MAX
//   hiscore   out  [SCORELEN] best finished-game score since reset
//   level     out  [3] speed level, saturates at 7
//   running   out  state is RUN
//   game_over out  state is OVER
module score_counter #(
  parameter int SCORELEN  = 13,
  parameter int TICK_DIV  = 2500,
  parameter int SCORE_MAX = 6399
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic                start,
  input  logic                collide,
  output logic [SCORELEN-1:0] score,
  output logic [SCORELEN-1:0] hiscore,
  output logic [2:0]          level,
  output logic                running,
  output logic                game_over
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [15:0]         TMAX = 16'(TICK_DIV - 1);
  localparam logic [SCORELEN-1:0] SMAX = SCORELEN'(SCORE_MAX);

  state_t      state;
  logic [15:0] presc;
  logic [6:0]  centi;   // points since last level step, 0..99
  logic        tick;

  assign tick      = (presc == TMAX);
  assign running   = (state == RUN);
  assign game_over = (state == OVER);

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      score   <= '0;
      hiscore <= '0;
      level   <= '0;
      presc   <= '0;
      centi   <= '0;
    end else begin
      case (state)
        IDLE, OVER: begin
          // collide is don't-care outside RUN
          if (start) begin
            state <= RUN;
            score <= '0;
            level <= '0;
            presc <= '0;
            centi <= '0;
          end
        end
        RUN: begin
          // collide wins over start and over a same-edge tick
          if (collide) begin
            state <= OVER;
            if (score > hiscore) hiscore <= score;
          end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick && score < SMAX) begin
              score <= score + SCORELEN'(1);
              if (centi == 7'd99) begin
                centi <= '0;
                if (level != 3'd7) level <= level + 3'd1;
              end else begin
                centi <= centi + 7'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_counter.sv
module tb_score_counter;

  logic        clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // DUT with TICK_DIV=4
  logic        rst4 = 1'b0, start4 = 1'b0, collide4 = 1'b0;
  logic [12:0] score4, hiscore4;
  logic [2:0]  level4;
  logic        running4, over4;

  // DUT with TICK_DIV=1
  logic        rst1 = 1'b0, start1 = 1'b0, collide1 = 1'b0;
  logic [12:0] score1, hiscore1;
  logic [2:0]  level1;
  logic        running1, over1;

  int n_chk  = 0;
  int n_pass = 0;

  score_counter #(.SCORELEN(13), .TICK_DIV(4), .SCORE_MAX(6399)) dut4 (
    .clk2(clk2), .rst(rst4), .start(start4), .collide(collide4),
    .score(score4), .hiscore(hiscore4), .level(level4),
    .running(running4), .game_over(over4)
  );

  score_counter #(.SCORELEN(13), .TICK_DIV(1), .SCORE_MAX(6399)) dut1 (
    .clk2(clk2), .rst(rst1), .start(start1), .collide(collide1),
    .score(score1), .hiscore(hiscore1), .level(level1),
    .running(running1), .game_over(over1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // advance n rising edges, land 1ns after the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  task automatic pulse_start4();
    start4 = 1'b1; cyc(1); start4 = 1'b0;
  endtask

  task automatic pulse_start1();
    start1 = 1'b1; cyc(1); start1 = 1'b0;
  endtask

  initial begin
    // reset state before any edge
    #3;
    chk("rst_score",   score4,   0);
    chk("rst_hiscore", hiscore4, 0);
    chk("rst_level",   level4,   0);
    chk("rst_running", running4, 0);
    chk("rst_over",    over4,    0);

    // release, idle holds without start
    cyc(1); rst4 = 1'b1;
    cyc(3);
    chk("idle_hold_run",   running4, 0);
    chk("idle_hold_score", score4,   0);
    collide4 = 1'b1; cyc(1); collide4 = 1'b0;
    chk("idle_collide_ign", over4, 0);

    // game: 20 edges -> score 5, then async reset between edges
    pulse_start4();
    chk("start_running", running4, 1);
    chk("start_score",   score4,   0);
    cyc(3);
    chk("pre_first_tick", score4, 0);
    cyc(1);
    chk("first_tick", score4, 1);
    cyc(16);
    chk("run20_score", score4, 5);
    #2 rst4 = 1'b0; #1;
    chk("async_score",   score4,   0);
    chk("async_running", running4, 0);
    chk("async_hiscore", hiscore4, 0);
    chk("async_level",   level4,   0);
    cyc(1); rst4 = 1'b1;
    cyc(3);
    chk("post_rst_idle",  running4, 0);
    chk("post_rst_score", score4,   0);

    // 40 cycles of RUN -> score 10
    pulse_start4();
    cyc(40);
    chk("run40_score",   score4,   10);
    chk("run40_level",   level4,   0);
    chk("run40_running", running4, 1);
    // start mid-game is ignored
    pulse_start4();
    chk("mid_start_score", score4,   10);
    chk("mid_start_run",   running4, 1);
    cyc(3);
    chk("mid_start_cont", score4, 11);

    // clean slate, then collide on the tick cycle at score 7
    #2 rst4 = 1'b0; cyc(1); rst4 = 1'b1; cyc(1);
    pulse_start4();
    cyc(31);   // presc now at 3, tick pending, score 7
    chk("pre_coll_score", score4, 7);
    collide4 = 1'b1; cyc(1); collide4 = 1'b0;
    chk("coll_score",   score4,   7);
    chk("coll_over",    over4,    1);
    chk("coll_running", running4, 0);
    chk("coll_hiscore", hiscore4, 7);
    cyc(10);
    chk("over_hold_score", score4, 7);
    chk("over_hold_flag",  over4,  1);

    // game 2: score 3 does not beat 7
    pulse_start4();
    chk("g2_score0", score4, 0);
    chk("g2_hi_kept", hiscore4, 7);
    cyc(12);
    chk("g2_score3", score4, 3);
    collide4 = 1'b1; cyc(1); collide4 = 1'b0;
    chk("g2_hiscore", hiscore4, 7);

    // game 3: score 12 beats 7
    pulse_start4();
    cyc(48);
    chk("g3_score12", score4, 12);
    collide4 = 1'b1; cyc(1); collide4 = 1'b0;
    chk("g3_hiscore", hiscore4, 12);

    // start+collide together in RUN -> OVER
    pulse_start4();
    cyc(4);
    start4 = 1'b1; collide4 = 1'b1; cyc(1); start4 = 1'b0; collide4 = 1'b0;
    chk("sc_over",    over4,    1);
    chk("sc_running", running4, 0);
    chk("sc_score",   score4,   1);
    pulse_start4();
    chk("restart_run",   running4, 1);
    chk("restart_score", score4,   0);
    chk("restart_hi",    hiscore4, 12);

    // TICK_DIV=1 instance
    cyc(1); rst1 = 1'b1; cyc(1);
    chk("d1_idle", running1, 0);
    pulse_start1();
    cyc(5);
    chk("d1_score5", score1, 5);
    collide1 = 1'b1; cyc(1); collide1 = 1'b0;
    chk("d1_coll_noinc", score1, 5);
    chk("d1_hiscore5",   hiscore1, 5);
    pulse_start1();
    cyc(99);
    chk("d1_score99_lvl", level1, 0);
    cyc(1);
    chk("d1_score100_lvl", level1, 1);
    cyc(150);
    chk("d1_score250", score1, 250);
    chk("d1_level2",   level1, 2);
    cyc(6399 - 250 - 1);
    chk("d1_score6398", score1, 6398);
    cyc(1);
    chk("d1_score6399", score1, 6399);
    cyc(20);
    chk("d1_sat_score", score1, 6399);
    chk("d1_sat_level", level1, 7);
    collide1 = 1'b1; cyc(1); collide1 = 1'b0;
    chk("d1_sat_hi",   hiscore1, 6399);
    chk("d1_sat_over", over1,    1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_counter.md
SCORE_COUNTER -- requirements
Module: score_counter

Interface
REQ-001 Parameter SCORELEN, default 13, width of score and hiscore buses.
REQ-002 Parameter TICK_DIV, default 2500, clk2 cycles per score point while running; legal range 1..65535.
REQ-003 Parameter SCORE_MAX, default 6399, saturation value, the largest score the score display can represent.
REQ-004 clk2  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  single-cycle pulse requesting a new game.
REQ-007 collide  input  1  level, dinosaur/obstacle collision.
REQ-008 score  output  SCORELEN  current game score, binary, registered.
REQ-009 hiscore  output  SCORELEN  best score since reset, registered.
REQ-010 level  output  3  speed level for the obstacle generator, registered.
REQ-011 running  output  1  high only in state RUN.
REQ-012 game_over  output  1  high only in state OVER.

Function
REQ-013 FSM states IDLE, RUN, OVER; running and game_over decode directly from the state register.
REQ-014 IDLE: start=1 -> RUN next cycle; score, level, prescaler, centi counter cleared on the same edge.
REQ-015 RUN: collide=1 -> OVER next cycle; collide takes priority over start and over a same-cycle tick (no increment on that edge).
REQ-016 OVER: start=1 -> RUN next cycle with score, level, prescaler and centi counter cleared; collide is ignored in OVER and IDLE.
REQ-017 Prescaler counts 0..TICK_DIV-1 only in RUN; tick asserted on the cycle it holds TICK_DIV-1, then wraps to 0.
REQ-018 On tick in RUN with score < SCORE_MAX: score increments by 1; at SCORE_MAX score holds, prescaler keeps wrapping.
REQ-019 Centi counter 0..99 increments with each score increment; on wrap 99->0 level increments by 1, saturating at 7; no divider is used.
REQ-020 Score update latency: score changes on the edge where tick is asserted; first increment occurs TICK_DIV cycles after entering RUN.
REQ-021 On RUN->OVER edge: hiscore loads score if score > hiscore, else holds; hiscore is never otherwise modified except by reset.
REQ-022 score and level hold their values throughout OVER until the next start.
REQ-023 start while RUN and collide=0 is ignored (no restart mid-game).
REQ-024 TICK_DIV=1: score increments every RUN cycle except the collision cycle.

Reset
REQ-025 rst=0 asynchronously forces state IDLE, score=0, hiscore=0, level=0, prescaler=0, centi=0, running=0, game_over=0.
REQ-026 rst asserted mid-RUN discards the game without updating hiscore; after release the block waits in IDLE for start.
REQ-027 Release of rst is synchronous-safe: no state change on the first edge after release unless start=1.

Verification
REQ-028 TICK_DIV=4: rst release, start pulse, 40 cycles RUN -> score=10, level=0, running=1.
REQ-029 TICK_DIV=1: run 250 cycles -> score=250, level=2; run to 6399+20 cycles -> score=6399, level=7.
REQ-030 TICK_DIV=4: collide asserted on a tick cycle at score=7 -> score stays 7, game_over=1 next cycle, hiscore=7.
REQ-031 Second game to score 3 then collide -> hiscore stays 7; third game to 12 -> hiscore=12.
REQ-032 start and collide same cycle in RUN -> OVER, no restart; start in OVER -> RUN, score=0, hiscore retained.
REQ-033 rst pulsed low mid-RUN at score=5 between clock edges -> all outputs 0 immediately, IDLE held until start.
